hitomezashi_gen: RTL and testbench

- Parametrised Hitomezashi stitch-pattern painter for the VGA path; sits between the display timing generator and the VGA Pmod output registers.
- Additions over the fixed-size painter:
  - configurable cell size and grid dimensions;
  - a valid/ready pattern-load port with frame-synchronous (tear-free) commit;
  - per-frame scrolling in X and Y with modulo wrap;
  - a 2-stage registered pixel pipeline with matched sync delay.

---
 rtl/hitomezashi_gen.sv | 170 +++++++++++++++++
 tb/tb_hitomezashi_gen.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/hitomezashi_gen.sv
// Hitomezashi stitch-pattern painter: scrollable, reloadable pattern with a
// 2-stage pixel pipeline and matched sync delay for the VGA output registers.
module hitomezashi_gen #(
  parameter int          CORDW     = 10,
  parameter int          CELL_LOG2 = 4,
  parameter int          NV        = 40,
  parameter int          NH        = 30,
  parameter int          V_RES     = 480,
  parameter int          STEP      = 1,
  parameter logic [NV-1:0] V_INIT  = '0,
  parameter logic [NH-1:0] H_INIT  = '0,
  parameter logic [11:0] FG        = 12'hFC0,
  parameter logic [11:0] BG        = 12'h137
) (
  input  logic             clk_pix,
  input  logic             rst_pix,
  input  logic [CORDW-1:0] sx,
  input  logic [CORDW-1:0] sy,
  input  logic             hsync,
  input  logic             vsync,
  input  logic             de,
  input  logic             pat_valid,
  output logic             pat_ready,
  input  logic [NV-1:0]    v_pat_in,
  input  logic [NH-1:0]    h_pat_in,
  input  logic             scroll_x_en,
  input  logic             scroll_y_en,
  output logic             commit,
  output logic             vga_hsync,
  output logic             vga_vsync,
  output logic [3:0]       vga_r,
  output logic [3:0]       vga_g,
  output logic [3:0]       vga_b
);

  // One extra bit so coordinate + offset never overflows before the wrap.
  localparam int OW = CORDW + 1;
  localparam int IW = OW - CELL_LOG2;
  localparam int CW = $clog2(NV);
  localparam int RW = $clog2(NH);

  localparam logic [OW-1:0]    W_C    = OW'(NV << CELL_LOG2);
  localparam logic [OW-1:0]    H_C    = OW'(NH << CELL_LOG2);
  localparam logic [OW-1:0]    STEP_C = OW'(STEP);
  localparam logic [CORDW-1:0] VRES_C = CORDW'(V_RES);
  localparam logic [IW-1:0]    NV_C   = IW'(NV);
  localparam logic [IW-1:0]    NH_C   = IW'(NH);

  function automatic logic [OW-1:0] wrap_add(input logic [OW-1:0] a,
                                             input logic [OW-1:0] b,
                                             input logic [OW-1:0] lim);
    logic [OW-1:0] s;
    s = a + b;
    return (s >= lim) ? (s - lim) : s;
  endfunction

  function automatic logic [11:0] paint(input logic vld, input logic stitch);
    return vld ? (stitch ? FG : BG) : 12'h000;
  endfunction

  logic [NV-1:0] v_act_q, v_act_d, v_pend_q, v_pend_d;
  logic [NH-1:0] h_act_q, h_act_d, h_pend_q, h_pend_d;
  logic          pend_q, pend_d, commit_q, commit_d;
  logic [OW-1:0] xoff_q, xoff_d, yoff_q, yoff_d;
  logic [OW-1:0] ex_p1_q, ex_p1_d, ey_p1_q, ey_p1_d;
  logic          vld_p1_q, vld_p1_d, hs_p1_q, hs_p1_d, vs_p1_q, vs_p1_d;
  logic [11:0]   rgb_p2_q, rgb_p2_d;
  logic          hs_p2_q, hs_p2_d, vs_p2_q, vs_p2_d;

  logic          frame_evt, xfer;
  logic [IW-1:0] col_full, row_full;
  logic [CW-1:0] col_idx;
  logic [RW-1:0] row_idx;
  logic          v_on, h_on, stitch;

  always_comb begin
    frame_evt = (sx == '0) && (sy == VRES_C);
    xfer      = pat_valid && !pend_q;

    v_act_d  = v_act_q;
    h_act_d  = h_act_q;
    v_pend_d = v_pend_q;
    h_pend_d = h_pend_q;
    pend_d   = pend_q;
    xoff_d   = xoff_q;
    yoff_d   = yoff_q;

    // Commit and capture are exclusive: capture needs the slot empty.
    commit_d = frame_evt && pend_q;
    if (commit_d) begin
      v_act_d = v_pend_q;
      h_act_d = h_pend_q;
      pend_d  = 1'b0;
    end
    if (xfer) begin
      pend_d   = 1'b1;
      v_pend_d = v_pat_in;
      h_pend_d = h_pat_in;
    end
    if (frame_evt && scroll_x_en) xoff_d = wrap_add(xoff_q, STEP_C, W_C);
    if (frame_evt && scroll_y_en) yoff_d = wrap_add(yoff_q, STEP_C, H_C);

    // Stage 1: scrolled, wrapped pattern coordinates
    ex_p1_d  = wrap_add({1'b0, sx}, xoff_q, W_C);
    ey_p1_d  = wrap_add({1'b0, sy}, yoff_q, H_C);
    vld_p1_d = de;
    hs_p1_d  = hsync;
    vs_p1_d  = vsync;

    // Stage 2: stitch decision and colour
    col_full = ex_p1_q[OW-1:CELL_LOG2];
    row_full = ey_p1_q[OW-1:CELL_LOG2];
    col_idx  = (col_full < NV_C) ? col_full[CW-1:0] : '0;
    row_idx  = (row_full < NH_C) ? row_full[RW-1:0] : '0;
    v_on     = ey_p1_q[CELL_LOG2] ^ v_act_q[col_idx];
    h_on     = ex_p1_q[CELL_LOG2] ^ h_act_q[row_idx];
    stitch   = ((ex_p1_q[CELL_LOG2-1:0] == '0) && v_on) ||
               ((ey_p1_q[CELL_LOG2-1:0] == '0) && h_on);
    rgb_p2_d = paint(vld_p1_q, stitch);
    hs_p2_d  = hs_p1_q;
    vs_p2_d  = vs_p1_q;
  end

  always_ff @(posedge clk_pix or posedge rst_pix) begin
    if (rst_pix) begin
      v_act_q  <= V_INIT;
      h_act_q  <= H_INIT;
      v_pend_q <= '0;
      h_pend_q <= '0;
      pend_q   <= 1'b0;
      commit_q <= 1'b0;
      xoff_q   <= '0;
      yoff_q   <= '0;
      ex_p1_q  <= '0;
      ey_p1_q  <= '0;
      vld_p1_q <= 1'b0;
      hs_p1_q  <= 1'b1;
      vs_p1_q  <= 1'b1;
      rgb_p2_q <= '0;
      hs_p2_q  <= 1'b1;
      vs_p2_q  <= 1'b1;
    end else begin
      v_act_q  <= v_act_d;
      h_act_q  <= h_act_d;
      v_pend_q <= v_pend_d;
      h_pend_q <= h_pend_d;
      pend_q   <= pend_d;
      commit_q <= commit_d;
      xoff_q   <= xoff_d;
      yoff_q   <= yoff_d;
      ex_p1_q  <= ex_p1_d;
      ey_p1_q  <= ey_p1_d;
      vld_p1_q <= vld_p1_d;
      hs_p1_q  <= hs_p1_d;
      vs_p1_q  <= vs_p1_d;
      rgb_p2_q <= rgb_p2_d;
      hs_p2_q  <= hs_p2_d;
      vs_p2_q  <= vs_p2_d;
    end
  end

  assign pat_ready = ~pend_q;
  assign commit    = commit_q;
  assign vga_hsync = hs_p2_q;
  assign vga_vsync = vs_p2_q;
  assign vga_r     = rgb_p2_q[11:8];
  assign vga_g     = rgb_p2_q[7:4];
  assign vga_b     = rgb_p2_q[3:0];

endmodule

// File: tb/tb_hitomezashi_gen.sv
// Randomised bench for hitomezashi_gen against a frame-level reference model
// of pattern state, handshake, scrolling and the pixel stitch rule.
module tb_hitomezashi_gen;

  localparam int W    = 640;
  localparam int H    = 480;
  localparam int CELL = 16;
  localparam int TSTEP = 1;
  localparam logic [39:0] VI = 40'h1;
  localparam logic [29:0] HI = 30'h0;
  localparam logic [11:0] FG = 12'hFC0;
  localparam logic [11:0] BG = 12'h137;

  logic        clk_pix, rst_pix;
  logic [9:0]  sx, sy;
  logic        hsync, vsync, de, pat_valid, pat_ready;
  logic [39:0] v_pat_in;
  logic [29:0] h_pat_in;
  logic        scroll_x_en, scroll_y_en, commit;
  logic        vga_hsync, vga_vsync;
  logic [3:0]  vga_r, vga_g, vga_b;

  hitomezashi_gen #(.CORDW(10), .CELL_LOG2(4), .NV(40), .NH(30), .V_RES(480),
                    .STEP(TSTEP), .V_INIT(VI), .H_INIT(HI), .FG(FG), .BG(BG)) dut (
    .clk_pix(clk_pix), .rst_pix(rst_pix), .sx(sx), .sy(sy), .hsync(hsync),
    .vsync(vsync), .de(de), .pat_valid(pat_valid), .pat_ready(pat_ready),
    .v_pat_in(v_pat_in), .h_pat_in(h_pat_in), .scroll_x_en(scroll_x_en),
    .scroll_y_en(scroll_y_en), .commit(commit), .vga_hsync(vga_hsync),
    .vga_vsync(vga_vsync), .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b));

  initial clk_pix = 1'b0;
  always #5 clk_pix = ~clk_pix;

  int n_chk = 0;
  int n_err = 0;
  int n_commit = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference state
  logic [39:0] m_vact, m_vpend;
  logic [29:0] m_hact, m_hpend;
  logic        m_pend;
  int          m_xoff, m_yoff;
  logic [11:0] e_rgb;
  logic        e_hs, e_vs;

  task automatic m_reset();
    m_vact = VI; m_hact = HI; m_pend = 1'b0;
    m_vpend = '0; m_hpend = '0;
    m_xoff = 0; m_yoff = 0;
    e_rgb = 12'h000; e_hs = 1'b1; e_vs = 1'b1;
  endtask

  function automatic logic [11:0] ref_rgb(input int x, input int y, input logic d);
    int ex, ey;
    logic von, hon;
    if (!d) return 12'h000;
    ex  = (x + m_xoff) % W;
    ey  = (y + m_yoff) % H;
    von = (((ey / CELL) % 2) == 1) ^ m_vact[ex / CELL];
    hon = (((ex / CELL) % 2) == 1) ^ m_hact[ey / CELL];
    return (((ex % CELL) == 0 && von) || ((ey % CELL) == 0 && hon)) ? FG : BG;
  endfunction

  // One pixel clock: drive, advance the model at the edge, check outputs.
  task automatic cyc(input int x, input int y, input logic d, input logic hs_i,
                     input logic vs_i, input logic pv, input logic [39:0] vin,
                     input logic [29:0] hin, input logic sxe, input logic sye);
    logic [11:0] n_rgb;
    logic fe, xf, cm;
    sx = 10'(x); sy = 10'(y); de = d; hsync = hs_i; vsync = vs_i;
    pat_valid = pv; v_pat_in = vin; h_pat_in = hin;
    scroll_x_en = sxe; scroll_y_en = sye;
    n_rgb = ref_rgb(x, y, d);
    fe = (x == 0) && (y == 480);
    xf = pv && !m_pend;
    cm = fe && m_pend;
    @(posedge clk_pix);
    #1;
    if (cm) begin m_vact = m_vpend; m_hact = m_hpend; m_pend = 1'b0; end
    if (xf) begin m_pend = 1'b1; m_vpend = vin; m_hpend = hin; end
    if (fe && sxe) m_xoff = (m_xoff + TSTEP) % W;
    if (fe && sye) m_yoff = (m_yoff + TSTEP) % H;
    if (commit) n_commit++;
    chk("commit", commit, cm);
    chk("pat_ready", pat_ready, !m_pend);
    chk("rgb", {vga_r, vga_g, vga_b}, e_rgb);
    chk("hsync", vga_hsync, e_hs);
    chk("vsync", vga_vsync, e_vs);
    e_rgb = n_rgb; e_hs = hs_i; e_vs = vs_i;
  endtask

  task automatic pix(input int x, input int y, input logic d);
    cyc(x, y, d, 1'b1, 1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic frame(input logic sxe, input logic sye);
    cyc(0, 480, 1'b0, 1'b1, 1'b1, 1'b0, '0, '0, sxe, sye);
  endtask

  task automatic px_const(input string tag, input int x, input int y,
                          input logic d, input logic [11:0] exp);
    pix(x, y, d);
    pix(700, 10, 1'b0);
    chk(tag, {vga_r, vga_g, vga_b}, exp);
  endtask

  task automatic reset_checks(input string pfx);
    chk({pfx, "_hsync"}, vga_hsync, 1'b1);
    chk({pfx, "_vsync"}, vga_vsync, 1'b1);
    chk({pfx, "_rgb"}, {vga_r, vga_g, vga_b}, 12'h000);
    chk({pfx, "_ready"}, pat_ready, 1'b1);
    chk({pfx, "_commit"}, commit, 1'b0);
  endtask

  initial begin
    logic [63:0] r;
    int x, y, k;
    logic d;
    rst_pix = 1'b1;
    sx = '0; sy = '0; hsync = 1'b1; vsync = 1'b1; de = 1'b0;
    pat_valid = 1'b0; v_pat_in = '0; h_pat_in = '0;
    scroll_x_en = 1'b0; scroll_y_en = 1'b0;
    repeat (3) @(posedge clk_pix);
    #1;
    reset_checks("rst");
    m_reset();
    rst_pix = 1'b0;

    // Initial pattern, no scroll
    px_const("px_0_0", 0, 0, 1'b1, FG);
    px_const("px_0_16", 0, 16, 1'b1, BG);
    px_const("px_1_0", 1, 0, 1'b1, BG);
    px_const("px_blank", 700, 10, 1'b0, 12'h000);

    // Three frames of X scroll
    repeat (3) frame(1'b1, 1'b0);
    px_const("px_637_0_x3", 637, 0, 1'b1, FG);
    px_const("px_0_0_x3", 0, 0, 1'b1, BG);

    // Handshake: second offer while full is ignored
    n_commit = 0;
    cyc(100, 100, 1'b1, 1'b1, 1'b1, 1'b1, 40'hFFFFFFFFFF, 30'h0, 1'b0, 1'b0);
    cyc(101, 100, 1'b1, 1'b1, 1'b1, 1'b1, 40'h5555555555, 30'h3, 1'b0, 1'b0);
    px_const("px_13_8_old", 13, 8, 1'b1, BG);
    frame(1'b0, 1'b0);
    pix(700, 10, 1'b0);
    chk("commit_cnt1", n_commit, 1);
    px_const("px_13_8_new", 13, 8, 1'b1, FG);

    // Offer coincident with the frame event commits one frame later
    n_commit = 0;
    cyc(0, 480, 1'b0, 1'b1, 1'b1, 1'b1, 40'h0, 30'h0, 1'b0, 1'b0);
    px_const("px_13_8_hold", 13, 8, 1'b1, FG);
    chk("commit_cnt0", n_commit, 0);
    frame(1'b0, 1'b0);
    px_const("px_13_8_late", 13, 8, 1'b1, BG);
    chk("commit_cnt_late", n_commit, 1);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      k = $urandom_range(1, 4);
      for (int j = 0; j < k; j++) begin
        x = $urandom_range(0, 799);
        y = $urandom_range(0, 524);
        d = (x < W && y < H) ? 1'($urandom_range(0, 3) != 0) : 1'b0;
        r = {$urandom(), $urandom()};
        cyc(x, y, d, r[63], r[62], 1'($urandom_range(0, 3) == 0),
            r[39:0], r[61:32], 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
      if ($urandom_range(0, 2) == 0) frame(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // Full wrap in both axes
    for (int i = 0; i < 640; i++) begin
      frame(1'b1, 1'b1);
      pix($urandom_range(0, W - 1), $urandom_range(0, H - 1), 1'b1);
    end

    // Asynchronous reset mid-frame with a pending pattern
    frame(1'b0, 1'b0);
    cyc(50, 50, 1'b1, 1'b0, 1'b0, 1'b1, 40'hFFFFFFFFFF, 30'h3FFFFFFF, 1'b0, 1'b0);
    pix(60, 50, 1'b1);
    #3 rst_pix = 1'b1;
    #1;
    reset_checks("midrst");
    @(posedge clk_pix);
    #1;
    rst_pix = 1'b0;
    m_reset();
    frame(1'b0, 1'b0);
    px_const("post_rst_0_0", 0, 0, 1'b1, FG);
    px_const("post_rst_13_8", 13, 8, 1'b1, BG);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
